ws2812_chain: RTL and testbench

Parametrised driver for a daisy-chain of WS2812B-class LEDs. It holds one color word per LED in a double-buffered frame store. On request it serialises the whole chain MSB-first onto a single pin, then holds the line low for the latch/reset gap. It sits between the board status logic, which writes pixels and requests frame updates, and the physical LED data pin.

---
 rtl/ws2812_chain.sv | 177 +++++++++++++++++
 tb/tb_ws2812_chain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain.sv
// WS2812B chain driver: double-buffered frame store, MSB-first serialiser, latch gap.
// Optional build macro WS2812_CHAIN_AUTOREFRESH_EN retransmits the shadow buffer continuously.
module ws2812_chain #(
    parameter int NUM_LEDS = 8,
    parameter int DATABITS = 24,
    parameter int CLKFREQ  = 10000000,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DATABITS-1:0] wr_data,
    input  logic                show_valid,
    output logic                show_ready,
    output logic                busy,
    output logic                frame_done,
    output logic                pin
);

    // Cycle counts rounded to nearest: floor(CLKFREQ * t + 0.5), t in units of 10 ns.
    localparam int T0H  = int'((64'(CLKFREQ) * 64'd35 + 64'd50_000_000) / 64'd100_000_000);
    localparam int T1H  = int'((64'(CLKFREQ) * 64'd70 + 64'd50_000_000) / 64'd100_000_000);
    localparam int T0L  = int'((64'(CLKFREQ) * 64'd80 + 64'd50_000_000) / 64'd100_000_000);
    localparam int T1L  = int'((64'(CLKFREQ) * 64'd60 + 64'd50_000_000) / 64'd100_000_000);
    localparam int TRES = int'((64'(CLKFREQ) + 64'd5_000) / 64'd10_000);
    localparam int CW   = $clog2(TRES + 1);
    localparam int BW   = (DATABITS > 1) ? $clog2(DATABITS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    if (T0H < 1 || T1H < 1 || T0L < 1 || T1L < 1 || TRES < 1) begin : g_timing_check
        $error("ws2812_chain: CLKFREQ too low to realise WS2812 pulse widths");
    end

    logic [DATABITS-1:0] r_shadow [NUM_LEDS];
    logic [DATABITS-1:0] r_active [NUM_LEDS];

    logic [2:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [DATABITS-1:0] r_shift;
    logic [BW-1:0]       r_bit;
    logic [AW-1:0]       r_led;
    logic                r_pin;
    logic                r_frame_done;

    logic                w_req;
    logic                w_accept;
    logic                w_last_bit;
    logic                w_last_led;
    logic [AW-1:0]       w_led_next;
    logic [DATABITS-1:0] w_next_word;
    logic [DATABITS-1:0] w_shift_next;
    logic                w_next_msb;

`ifdef WS2812_CHAIN_AUTOREFRESH_EN
    assign w_req = show_valid | 1'b1;
`else
    assign w_req = show_valid;
`endif

    assign w_accept     = w_req && (r_state == S_IDLE);
    assign w_last_bit   = (r_bit == BW'(DATABITS - 1));
    assign w_last_led   = (r_led == AW'(NUM_LEDS - 1));
    assign w_led_next   = r_led + 1'b1;
    assign w_next_word  = r_active[w_led_next];
    assign w_shift_next = r_shift << 1;
    // The MSB of whatever goes out next selects the width of the coming high phase.
    assign w_next_msb   = w_last_bit ? w_next_word[DATABITS-1] : w_shift_next[DATABITS-1];

    function automatic logic [CW-1:0] high_cycles(input logic b);
        return b ? CW'(T1H - 1) : CW'(T0H - 1);
    endfunction

    function automatic logic [CW-1:0] low_cycles(input logic b);
        return b ? CW'(T1L - 1) : CW'(T0L - 1);
    endfunction

    // Shadow takes writes at any time; active snapshots the pre-write shadow on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    r_shadow[i] <= wr_data;
                end
                if (w_accept) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_led        <= '0;
            r_pin        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift <= r_active[0];
                    r_bit   <= '0;
                    r_led   <= '0;
                    r_pin   <= 1'b1;
                    r_cnt   <= high_cycles(r_active[0][DATABITS-1]);
                    r_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        r_pin   <= 1'b0;
                        r_cnt   <= low_cycles(r_shift[DATABITS-1]);
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_last_bit && w_last_led) begin
                        r_cnt   <= CW'(TRES - 1);
                        r_state <= S_GAP;
                    end else begin
                        r_pin   <= 1'b1;
                        r_cnt   <= high_cycles(w_next_msb);
                        r_state <= S_HIGH;
                        if (w_last_bit) begin
                            r_shift <= w_next_word;
                            r_bit   <= '0;
                            r_led   <= w_led_next;
                        end else begin
                            r_shift <= w_shift_next;
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pin   <= 1'b0;
                end
            endcase
        end
    end

    assign show_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign pin        = r_pin;

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain: expected pin waveform built per frame from the bit-timing rules.
module tb_ws2812_chain;
    localparam int NL = 3;
    localparam int DB = 24;
    localparam int CF = 10_000_000;
    localparam int AW = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DB-1:0] wr_data    = '0;
    logic          show_valid = 1'b0;
    logic          show_ready;
    logic          busy;
    logic          frame_done;
    logic          pin;

    ws2812_chain #(.NUM_LEDS(NL), .DATABITS(DB), .CLKFREQ(CF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .show_valid (show_valid),
        .show_ready (show_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .pin        (pin)
    );

    always #50 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int t0h, t1h, t0l, t1l, tres;
    logic [DB-1:0] m_shadow [NL];
    logic [DB-1:0] m_active [NL];
    bit exp_q [$];

    function automatic int cyc(input longint ns);
        return int'((longint'(CF) * ns + 64'sd500000000) / 64'sd1000000000);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // LED 0 first, MSB first, each bit a high run then a low run, then the latch gap.
    function automatic void build_expected();
        exp_q.delete();
        for (int led = 0; led < NL; led++) begin
            for (int b = DB - 1; b >= 0; b--) begin
                bit v = m_active[led][b];
                repeat (v ? t1h : t0h) exp_q.push_back(1'b1);
                repeat (v ? t1l : t0l) exp_q.push_back(1'b0);
            end
        end
        repeat (tres) exp_q.push_back(1'b0);
    endfunction

    task automatic drive_write(input int a, input logic [DB-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (a < NL) m_shadow[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    // Called at a negedge; returns at the negedge inside the LOAD cycle.
    task automatic accept(input string tag, input bit hold, input bit with_wr,
                          input int wa, input logic [DB-1:0] wd);
        show_valid = 1'b1;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_addr = AW'(wa);
            wr_data = wd;
        end
        @(posedge clk);
        m_active = m_shadow;
        if (with_wr && wa < NL) m_shadow[wa] = wd;
        @(negedge clk);
        wr_en = 1'b0;
        if (!hold) show_valid = 1'b0;
        check({tag, "_busy_load"}, busy, 1);
        check({tag, "_ready_load"}, show_ready, 0);
        check({tag, "_pin_load"}, pin, 0);
    endtask

    // Runs from the LOAD cycle to the frame_done cycle; optional shadow write mid-frame.
    task automatic check_frame(input string tag, input int wr_at, input int wa,
                               input logic [DB-1:0] wd);
        int pin_err = 0;
        int fd_err = 0;
        int busy_err = 0;
        build_expected();
        foreach (exp_q[i]) begin
            @(negedge clk);
            if (pin !== exp_q[i]) pin_err++;
            if (frame_done !== 1'b0) fd_err++;
            if (busy !== 1'b1) busy_err++;
            if (i == wr_at) drive_write(wa, wd);
            else wr_en = 1'b0;
        end
        @(negedge clk);
        wr_en = 1'b0;
        check({tag, "_pin_wave_errs"}, pin_err, 0);
        check({tag, "_early_done"}, fd_err, 0);
        check({tag, "_busy_drop"}, busy_err, 0);
        check({tag, "_frame_done"}, frame_done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_ready_end"}, show_ready, 1);
        check({tag, "_pin_end"}, pin, 0);
        $display("[TB] frame %s: %0d cycles, led0=%06h pin_errs=%0d", tag, exp_q.size(), m_active[0], pin_err);
    endtask

    initial begin
        #(100 * 90000);
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int quiet_err;
        t0h  = cyc(350);
        t1h  = cyc(700);
        t0l  = cyc(800);
        t1l  = cyc(600);
        tres = cyc(100000);
        clear_model();

        #1;
        check("reset_pin", pin, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", show_ready, 1);
        check("reset_done", frame_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

`ifdef WS2812_CHAIN_AUTOREFRESH_EN
        for (int f = 0; f < 3; f++) begin
            @(posedge clk);
            m_active = m_shadow;
            @(negedge clk);
            check("auto_busy_load", busy, 1);
            check_frame("auto", (f == 0) ? 50 : -1, 0, 24'h00AA55);
        end
`else
        @(negedge clk);
        check("idle_ready", show_ready, 1);
        check("idle_busy", busy, 0);

        drive_write(0, 24'hFF0000);
        @(negedge clk);
        drive_write(1, 24'h000001);
        @(negedge clk);
        wr_en = 1'b0;
        accept("plan", 1'b0, 1'b0, 0, '0);
        check_frame("plan", -1, 0, '0);

        accept("samecyc", 1'b0, 1'b1, 0, 24'h00000F);
        check_frame("samecyc", -1, 0, '0);
        accept("after_samecyc", 1'b0, 1'b0, 0, '0);
        check_frame("after_samecyc", -1, 0, '0);

        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NL; k++) begin
                drive_write(k, DB'($urandom()));
                @(negedge clk);
            end
            wr_en = 1'b0;
            accept("rnd", 1'b0, 1'b0, 0, '0);
            check_frame("rnd", int'($urandom_range(0, 500)), int'($urandom_range(0, NL)), DB'($urandom()));
        end

        drive_write(NL, DB'($urandom()));
        @(negedge clk);
        wr_en = 1'b0;
        accept("held0", 1'b1, 1'b0, 0, '0);
        check_frame("held0", 100, NL, DB'($urandom()));
        accept("held1", 1'b1, 1'b0, 0, '0);
        check_frame("held1", 200, 1, DB'($urandom()));
        accept("held2", 1'b1, 1'b0, 0, '0);
        check_frame("held2", -1, 0, '0);
        show_valid = 1'b0;
        quiet_err = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0) quiet_err++;
        end
        check("held_stop_idle", quiet_err, 0);

        drive_write(0, DB'($urandom()) | 24'h800000);
        @(negedge clk);
        wr_en = 1'b0;
        accept("rst", 1'b0, 1'b0, 0, '0);
        s = 0;
        for (int b = 0; b < 10; b++) begin
            s += m_active[0][DB-1-b] ? (t1h + t1l) : (t0h + t0l);
        end
        repeat (s + 2) @(negedge clk);
        check("rst_pre_pin", pin, 1);
        #10 rst_n = 1'b0;
        #1;
        check("rst_async_pin", pin, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_ready", show_ready, 1);
        check("rst_async_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        quiet_err = 0;
        repeat (1200) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0 || pin !== 1'b0) quiet_err++;
        end
        check("rst_no_frame_done", quiet_err, 0);
        check("rst_ready_after", show_ready, 1);
        accept("zero", 1'b0, 1'b0, 0, '0);
        check_frame("zero", -1, 0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
